// File: rtl/exception_control_unit_pkg.sv
// Shared definitions for the exception control unit.
//   - cause_t : encoding of the latched exception cause (also driven on Exc_Cause)
//   - state_t : FSM state encoding
//   - DEF_VEC_* : default byte addresses of the handler vectors
//   - vec_for_cause() : maps a cause to its vector address
package exception_control_unit_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_OPCODE = 2'd1,
      CAUSE_OVF    = 2'd2,
      CAUSE_DIVZ   = 2'd3
   } cause_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SAVE_EPC = 3'd1,
      ST_MEM_REQ  = 3'd2,
      ST_MEM_WAIT = 3'd3,
      ST_LOAD_PC  = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam int DEF_VEC_OPCODE   = 253;
   localparam int DEF_VEC_OVERFLOW = 254;
   localparam int DEF_VEC_DIVZERO  = 255;

   // Vector addresses are passed in so that the top-level parameters win
   // over the package defaults.
   function automatic logic [31:0] vec_for_cause(input cause_t cause,
                                                 input logic [31:0] vec_opcode,
                                                 input logic [31:0] vec_overflow,
                                                 input logic [31:0] vec_divzero);
      logic [31:0] addr;
      addr = 32'd0;
      case (cause)
         CAUSE_OPCODE: addr = vec_opcode;
         CAUSE_OVF:    addr = vec_overflow;
         CAUSE_DIVZ:   addr = vec_divzero;
         default:      addr = 32'd0;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/exception_control_unit.sv
// Exception entry sequencer for the multicycle MIPS datapath.
// On an enabled exception it saves EPC = PC-4, reads the handler byte from
// the cause's vector address and loads PC with that byte, zero-extended.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   AllowException    - sources are sampled only while high
//   OPCode_Error, Overflow, Div_Zero - exception sources
//   PC_In             - current PC value, captured on the trigger edge
//   Mem_Data_In       - handler byte returned by memory
//   Exception_Signal  - busy flag, high in every state except IDLE
//   Exc_Cause         - latched cause, held until the next trigger
//   Exc_EPC_Write/Exc_EPC_Value - EPC load strobe and value
//   Exc_Mem_Read/Exc_Mem_Addr   - memory read request and vector address
//   Exc_PC_Write/Exc_PC_Value   - PC load strobe and value
//   Exc_Done          - one-cycle completion pulse
//
// Handshake: there is no ready/valid pairing here. Memory is assumed to
// return valid data exactly MEM_LATENCY cycles after the request cycle, so
// Exc_Mem_Read is held for the request cycle plus MEM_LATENCY wait cycles
// and Mem_Data_In is consumed in the cycle right after the last wait cycle.
module exception_control_unit
   import exception_control_unit_pkg::*;
#(
   parameter int MEM_LATENCY  = 1,
   parameter int VEC_OPCODE   = DEF_VEC_OPCODE,
   parameter int VEC_OVERFLOW = DEF_VEC_OVERFLOW,
   parameter int VEC_DIVZERO  = DEF_VEC_DIVZERO
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        AllowException,
   input  logic        OPCode_Error,
   input  logic        Overflow,
   input  logic        Div_Zero,
   input  logic [31:0] PC_In,
   input  logic [7:0]  Mem_Data_In,
   output logic        Exception_Signal,
   output logic [1:0]  Exc_Cause,
   output logic        Exc_EPC_Write,
   output logic [31:0] Exc_EPC_Value,
   output logic        Exc_Mem_Read,
   output logic [31:0] Exc_Mem_Addr,
   output logic        Exc_PC_Write,
   output logic [31:0] Exc_PC_Value,
   output logic        Exc_Done
);

   localparam logic [2:0] LAT = 3'(MEM_LATENCY);

   state_t      state;
   state_t      state_next;
   cause_t      cause_q;
   cause_t      trig_cause;
   logic        trigger;
   logic [31:0] pc_q;
   logic [2:0]  wait_cnt;
   logic [31:0] vec_addr;

   // Priority: invalid opcode beats divide-by-zero beats overflow.
   always_comb begin
      trig_cause = CAUSE_NONE;
      if (OPCode_Error)  trig_cause = CAUSE_OPCODE;
      else if (Div_Zero) trig_cause = CAUSE_DIVZ;
      else if (Overflow) trig_cause = CAUSE_OVF;
   end

   assign trigger = AllowException && (OPCode_Error || Div_Zero || Overflow);

   assign vec_addr = vec_for_cause(cause_q, 32'(VEC_OPCODE),
                                   32'(VEC_OVERFLOW), 32'(VEC_DIVZERO));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cause_q  <= CAUSE_NONE;
         pc_q     <= 32'd0;
         wait_cnt <= 3'd0;
      end else begin
         state <= state_next;
         // Sources are only looked at in IDLE; anything raised while busy is dropped.
         if (state == ST_IDLE && trigger) begin
            cause_q <= trig_cause;
            pc_q    <= PC_In;
         end
         if (state == ST_MEM_REQ)
            wait_cnt <= LAT;
         else if (state == ST_MEM_WAIT)
            wait_cnt <= wait_cnt - 3'd1;
      end
   end

   always_comb begin
      state_next       = state;
      Exception_Signal = 1'b1;
      Exc_EPC_Write    = 1'b0;
      Exc_EPC_Value    = 32'd0;
      Exc_Mem_Read     = 1'b0;
      Exc_Mem_Addr     = 32'd0;
      Exc_PC_Write     = 1'b0;
      Exc_PC_Value     = 32'd0;
      Exc_Done         = 1'b0;
      case (state)
         ST_IDLE: begin
            Exception_Signal = 1'b0;
            if (trigger) state_next = ST_SAVE_EPC;
         end
         ST_SAVE_EPC: begin
            Exc_EPC_Write = 1'b1;
            Exc_EPC_Value = pc_q - 32'd4;
            state_next    = ST_MEM_REQ;
         end
         ST_MEM_REQ: begin
            Exc_Mem_Read = 1'b1;
            Exc_Mem_Addr = vec_addr;
            state_next   = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            Exc_Mem_Read = 1'b1;
            Exc_Mem_Addr = vec_addr;
            // Counter was loaded with MEM_LATENCY, so this state lasts that many cycles.
            if (wait_cnt == 3'd1) state_next = ST_LOAD_PC;
         end
         ST_LOAD_PC: begin
            Exc_PC_Write = 1'b1;
            Exc_PC_Value = {24'd0, Mem_Data_In};
            state_next   = ST_DONE;
         end
         ST_DONE: begin
            Exc_Done   = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            Exception_Signal = 1'b0;
            state_next       = ST_IDLE;
         end
      endcase
   end

   assign Exc_Cause = cause_q;

endmodule

// File: tb/tb_exception_control_unit.sv
// Bench for exception_control_unit: two instances (MEM_LATENCY 1 and 3)
// share all inputs. A timeline model predicts each instance's outputs from
// the number of clock edges since the trigger edge.
module tb_exception_control_unit;

   logic        clk;
   logic        reset;
   logic        allow;
   logic        opc_err;
   logic        ovf;
   logic        divz;
   logic [31:0] pc_in;
   logic [7:0]  mem_data;

   logic        sig     [2];
   logic [1:0]  cause   [2];
   logic        epc_w   [2];
   logic [31:0] epc_v   [2];
   logic        mem_rd  [2];
   logic [31:0] mem_addr[2];
   logic        pc_w    [2];
   logic [31:0] pc_v    [2];
   logic        done    [2];

   int checks;
   int failures;

   // Model state: edges since trigger (0 = idle), latched cause and PC.
   int          m_phase[2];
   logic [1:0]  m_cause[2];
   logic [31:0] m_pc   [2];
   int          lat    [2];

   exception_control_unit #(.MEM_LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .AllowException(allow), .OPCode_Error(opc_err),
      .Overflow(ovf), .Div_Zero(divz), .PC_In(pc_in), .Mem_Data_In(mem_data),
      .Exception_Signal(sig[0]), .Exc_Cause(cause[0]), .Exc_EPC_Write(epc_w[0]),
      .Exc_EPC_Value(epc_v[0]), .Exc_Mem_Read(mem_rd[0]), .Exc_Mem_Addr(mem_addr[0]),
      .Exc_PC_Write(pc_w[0]), .Exc_PC_Value(pc_v[0]), .Exc_Done(done[0])
   );

   exception_control_unit #(.MEM_LATENCY(3)) u_lat3 (
      .clk(clk), .reset(reset), .AllowException(allow), .OPCode_Error(opc_err),
      .Overflow(ovf), .Div_Zero(divz), .PC_In(pc_in), .Mem_Data_In(mem_data),
      .Exception_Signal(sig[1]), .Exc_Cause(cause[1]), .Exc_EPC_Write(epc_w[1]),
      .Exc_EPC_Value(epc_v[1]), .Exc_Mem_Read(mem_rd[1]), .Exc_Mem_Addr(mem_addr[1]),
      .Exc_PC_Write(pc_w[1]), .Exc_PC_Value(pc_v[1]), .Exc_Done(done[1])
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vec_of(input logic [1:0] c);
      case (c)
         2'd1:    return 32'd253;
         2'd2:    return 32'd254;
         2'd3:    return 32'd255;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 0;
         m_cause[i] = 2'd0;
         m_pc[i]    = 32'd0;
      end
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_phase[i] = 0;
            m_cause[i] = 2'd0;
            m_pc[i]    = 32'd0;
         end else if (m_phase[i] == 0) begin
            if (allow && (opc_err || ovf || divz)) begin
               m_phase[i] = 1;
               m_pc[i]    = pc_in;
               m_cause[i] = opc_err ? 2'd1 : (divz ? 2'd3 : 2'd2);
            end
         end else if (m_phase[i] >= 4 + lat[i]) begin
            m_phase[i] = 0;
         end else begin
            m_phase[i] = m_phase[i] + 1;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         int  p;
         logic rd;
         p  = m_phase[i];
         rd = (p >= 2) && (p <= 2 + lat[i]);
         check($sformatf("sig%0d", i),   32'(sig[i]),   32'(p != 0));
         check($sformatf("cause%0d", i), 32'(cause[i]), 32'(m_cause[i]));
         check($sformatf("epcw%0d", i),  32'(epc_w[i]), 32'(p == 1));
         check($sformatf("epcv%0d", i),  epc_v[i],      (p == 1) ? m_pc[i] - 32'd4 : 32'd0);
         check($sformatf("memrd%0d", i), 32'(mem_rd[i]), 32'(rd));
         check($sformatf("addr%0d", i),  mem_addr[i],   rd ? vec_of(m_cause[i]) : 32'd0);
         check($sformatf("pcw%0d", i),   32'(pc_w[i]),  32'(p == 3 + lat[i]));
         check($sformatf("pcv%0d", i),   pc_v[i],       (p == 3 + lat[i]) ? {24'd0, mem_data} : 32'd0);
         check($sformatf("done%0d", i),  32'(done[i]),  32'(p == 4 + lat[i]));
         check($sformatf("onehot%0d", i), 32'(epc_w[i]) + 32'(mem_rd[i]) + 32'(pc_w[i]) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
      end
   endtask

   // One clock: edge, model update, sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic clear_sources();
      opc_err = 1'b0;
      ovf     = 1'b0;
      divz    = 1'b0;
   endtask

   initial begin
      int first_pcw;
      int done_cnt;
      checks   = 0;
      failures = 0;
      lat[0]   = 1;
      lat[1]   = 3;
      model_reset();

      // Reset
      reset    = 1'b1;
      allow    = 1'b0;
      clear_sources();
      pc_in    = 32'd0;
      mem_data = 8'd0;
      tick();
      tick();
      #2 reset = 1'b0;
      tick();
      check("reset_cause", 32'(cause[0]), 32'd0);

      // Overflow at PC 0x40, memory returns 0x7C
      allow    = 1'b1;
      pc_in    = 32'h40;
      mem_data = 8'h7C;
      ovf      = 1'b1;
      tick();
      ovf = 1'b0;
      check("ovf_epc", epc_v[0], 32'h3C);
      check("ovf_cause", 32'(cause[0]), 32'd2);
      tick();
      check("ovf_addr_t2", mem_addr[0], 32'd254);
      tick();
      check("ovf_addr_t3", mem_addr[0], 32'd254);
      tick();
      check("ovf_pcv", pc_v[0], 32'h7C);
      check("ovf_pcw", 32'(pc_w[0]), 32'd1);
      tick();
      check("ovf_done", 32'(done[0]), 32'd1);
      repeat (4) tick();

      // Priority: all sources together
      opc_err = 1'b1; divz = 1'b1; ovf = 1'b1;
      pc_in   = 32'h100;
      tick();
      clear_sources();
      check("prio_cause", 32'(cause[1]), 32'd1);
      tick();
      check("prio_addr", mem_addr[1], 32'd253);
      repeat (7) tick();

      // Gating: divide-by-zero held with AllowException low
      allow = 1'b0;
      divz  = 1'b1;
      pc_in = 32'h200;
      repeat (10) tick();
      check("gate_idle", 32'(sig[0]), 32'd0);
      allow = 1'b1;
      tick();
      divz = 1'b0;
      tick();
      check("gate_addr", mem_addr[0], 32'd255);
      repeat (7) tick();

      // Busy ignore: overflow re-raised during the memory wait
      pc_in    = 32'h300;
      mem_data = 8'h55;
      ovf      = 1'b1;
      tick();
      ovf = 1'b0;
      tick();
      tick();
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done[1]) done_cnt++;
      end
      check("busy_done_count", 32'(done_cnt), 32'd1);
      check("busy_idle", 32'(sig[1]), 32'd0);

      // Reset mid-sequence
      pc_in = 32'h400;
      divz  = 1'b1;
      tick();
      divz = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      tick();
      tick();
      #2 reset = 1'b0;
      repeat (3) tick();

      // Wrap and latency: PC 0 with MEM_LATENCY 3
      pc_in    = 32'd0;
      mem_data = 8'hA5;
      ovf      = 1'b1;
      tick();
      ovf = 1'b0;
      check("wrap_epc", epc_v[1], 32'hFFFF_FFFC);
      first_pcw = 0;
      for (int k = 2; k <= 9; k++) begin
         tick();
         if (pc_w[1] && first_pcw == 0) first_pcw = k;
      end
      check("lat3_pcw_edge", 32'(first_pcw), 32'd6);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         allow    = 1'($urandom_range(0, 1));
         opc_err  = ($urandom_range(0, 7) == 0);
         ovf      = ($urandom_range(0, 5) == 0);
         divz     = ($urandom_range(0, 7) == 0);
         pc_in    = $urandom;
         mem_data = 8'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exception_control_unit.md
Name: exception_control_unit

Overview:
- Handles exception entry for the multicycle MIPS datapath. It is the counterpart that drives the control unit's Exception_Signal input and consumes its AllowException/OPCode_Error outputs.
- On an enabled exception it:
  - saves EPC = PC-4,
  - reads the handler byte from the fixed vector address (253/254/255),
  - loads PC with that byte, zero-extended.
- The main control unit holds off (stalls its FSM) while Exception_Signal is high.

Parameters:
- MEM_LATENCY, 1, wait cycles between memory read request and valid Mem_Data_In (range 1..7).
- VEC_OPCODE, 253, byte address of the handler for an invalid opcode.
- VEC_OVERFLOW, 254, byte address of the handler for ALU overflow.
- VEC_DIVZERO, 255, byte address of the handler for divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- AllowException  in  1  from control unit; exception sources are sampled only when high.
- OPCode_Error  in  1  from control unit; invalid opcode.
- Overflow  in  1  from ALU; signed overflow.
- Div_Zero  in  1  from divider; divisor == 0.
- PC_In  in  32  current PC register value.
- Mem_Data_In  in  8  byte read from memory.
- Exception_Signal  out  1  busy flag to the control unit.
- Exc_Cause  out  2  latched cause: 0 none, 1 opcode, 2 overflow, 3 divzero.
- Exc_EPC_Write  out  1  EPC load strobe.
- Exc_EPC_Value  out  32  value to load into EPC.
- Exc_Mem_Read  out  1  memory read request.
- Exc_Mem_Addr  out  32  vector address.
- Exc_PC_Write  out  1  PC load strobe.
- Exc_PC_Value  out  32  new PC.
- Exc_Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high. While reset is high:
  - state = IDLE;
  - every output is 0, including Exc_Cause = 0 and all 32-bit outputs;
  - captured PC and wait counter = 0.
- Reset mid-sequence aborts immediately. No partial EPC or PC write completes after reset asserts.
- Trigger: in IDLE, on a rising edge where AllowException = 1 and any source is high, latch the cause and PC_In, then go to SAVE_EPC.
  - Priority: OPCode_Error > Div_Zero > Overflow.
  - Sources with AllowException = 0 are ignored.
- States (Moore outputs decoded from the state register):
  - IDLE: all strobes 0; Exception_Signal = 0.
  - SAVE_EPC: Exc_EPC_Write = 1; Exc_EPC_Value = captured PC - 4, 32-bit modulo (PC 0 gives 0xFFFFFFFC). Next: MEM_REQ.
  - MEM_REQ: Exc_Mem_Read = 1; Exc_Mem_Addr = vector for the latched cause, zero-extended to 32 bits. Load wait counter with MEM_LATENCY. Next: MEM_WAIT.
  - MEM_WAIT: Exc_Mem_Read = 1 and address held stable. Counter decrements each cycle; at 1, next is LOAD_PC. MEM_WAIT therefore lasts exactly MEM_LATENCY cycles.
  - LOAD_PC: Exc_PC_Write = 1; Exc_PC_Value = {24'b0, Mem_Data_In}, sampled this cycle. Next: DONE.
  - DONE: Exc_Done = 1 for one cycle. Next: IDLE.
- Exception_Signal = 1 in every state except IDLE.
- Exc_Cause holds its latched value until the next trigger. It is cleared only by reset.
- Latency: trigger edge to Exc_PC_Write = 3 + MEM_LATENCY cycles; to Exc_Done = 4 + MEM_LATENCY cycles.
- Exc_Done to the next possible trigger: earliest trigger is the edge that ends the IDLE cycle following DONE. Back-to-back exceptions are therefore separated by at least one IDLE cycle.
- New source assertions while busy are ignored, not queued.
- Simultaneous sources: only the highest-priority cause is serviced.
- Strobes are never asserted together. At most one of Exc_EPC_Write / Exc_Mem_Read / Exc_PC_Write is high in any cycle.

Decomposition:
- Shared package / include holds:
  - cause encodings (CAUSE_NONE/OPCODE/OVF/DIVZ);
  - state encodings (3-bit: IDLE, SAVE_EPC, MEM_REQ, MEM_WAIT, LOAD_PC, DONE);
  - default vector addresses 253/254/255.
- No sub-module. The wait counter is an inline 3-bit register, so the block is a single FSM.

Test Plan:
- Overflow: AllowException = 1, Overflow pulse at PC_In = 0x00000040, memory returns 0x7C, MEM_LATENCY = 1.
  -> Exc_EPC_Value = 0x3C with Exc_EPC_Write at T+1; Exc_Mem_Addr = 254 at T+2..T+3; Exc_PC_Value = 0x0000007C with Exc_PC_Write at T+4; Exc_Done at T+5; Exc_Cause = 2.
- Priority: OPCode_Error, Div_Zero and Overflow high together.
  -> Exc_Mem_Addr = 253, Exc_Cause = 1; only one sequence runs.
- Gating: Div_Zero = 1 with AllowException = 0 for 10 cycles.
  -> Exception_Signal stays 0 and no strobes fire. Raising AllowException then triggers with Exc_Mem_Addr = 255.
- Busy ignore: Overflow re-asserted during MEM_WAIT.
  -> single sequence, single Exc_Done, returns to IDLE with no second trigger.
- Reset mid-sequence: assert reset in MEM_WAIT.
  -> all outputs 0 asynchronously, Exc_Cause = 0, Exc_PC_Write never pulses. After release, IDLE.
- Wrap and latency: PC_In = 0, MEM_LATENCY = 3.
  -> Exc_EPC_Value = 0xFFFFFFFC; Exc_PC_Write exactly 6 cycles after the trigger edge.
